// File: rtl/digit_entry_ctrl.sv
// digit_entry_ctrl: 4-digit BCD operand entry from board switches/buttons.
// Raw buttons are synchronised and debounced. A press/hold/auto-repeat FSM
// edits the switch-selected digit. A commit press hands the value to the
// core over a valid/ready handshake.
//
// Build option: define DIGIT_WRAP_EN to make digit steps wrap modulo 10
// (9+1 -> 0, 0-1 -> 9). Without it, steps saturate at 9 and at 0.
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a clean single inc/dec press on a one-hot sw
//   S_HOLD   | first step done, counting REPEAT_DELAY while act is held
//   S_REPEAT | auto-repeat, one step every REPEAT_PERIOD cycles
module digit_entry_ctrl #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] REPEAT_DELAY    = 24'd25000000,
   parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  sw,
   input  logic        btn_inc,
   input  logic        btn_dec,
   input  logic        btn_commit,
   output logic [15:0] digits,
   output logic [15:0] val_data,
   output logic        val_valid,
   input  logic        val_ready
);

   localparam int B_INC = 0;
   localparam int B_DEC = 1;
   localparam int B_COM = 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   logic [2:0]  btn_raw;
   logic [2:0]  sync1_q, sync2_q;
   logic [2:0]  lvl_q, lvl_prev_q;
   logic [15:0] db_cnt_q [3];
   logic [2:0]  press;

   state_t      state_q;
   logic [23:0] hold_cnt_q;
   logic        act_dec_q;
   logic [3:0]  sw_lat_q;
   logic [15:0] digits_q, digits_d;
   logic [15:0] val_data_q;
   logic        val_valid_q;

   logic        sw_onehot;
   logic        act_lvl, oth_lvl;
   logic        abort;
   logic        start;
   logic        step_en;
   logic        step_dec;
   logic [3:0]  step_sel;

   assign btn_raw = {btn_commit, btn_dec, btn_inc};

   // One BCD digit step; wrap or saturate depending on the build option.
   function automatic logic [3:0] step_digit(input logic [3:0] d, input logic dn);
      logic [3:0] r;
`ifdef DIGIT_WRAP_EN
      if (dn) r = (d == 4'd0) ? 4'd9 : d - 4'd1;
      else    r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
`else
      if (dn) r = (d == 4'd0) ? 4'd0 : d - 4'd1;
      else    r = (d >= 4'd9) ? 4'd9 : d + 4'd1;
`endif
      return r;
   endfunction

   // Two-flop synchronisers for the raw buttons.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debouncers: level flips after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q      <= 3'b000;
         lvl_prev_q <= 3'b000;
         for (int i = 0; i < 3; i++) db_cnt_q[i] <= 16'd0;
      end else begin
         lvl_prev_q <= lvl_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
               db_cnt_q[i] <= 16'd0;
            end else if (db_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
               lvl_q[i]    <= ~lvl_q[i];
               db_cnt_q[i] <= 16'd0;
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 16'd1;
            end
         end
      end
   end

   assign press = lvl_q & ~lvl_prev_q;

   // Entry, abort and step decisions for the edit FSM.
   always_comb begin
      sw_onehot = (sw != 4'd0) && ((sw & (sw - 4'd1)) == 4'd0);
      act_lvl   = act_dec_q ? lvl_q[B_DEC] : lvl_q[B_INC];
      oth_lvl   = act_dec_q ? lvl_q[B_INC] : lvl_q[B_DEC];
      // The other button was low on entry, so seeing it high means it rose.
      abort     = !act_lvl || oth_lvl || (sw != sw_lat_q);
      start     = (press[B_INC] ^ press[B_DEC]) &&
                  !(press[B_INC] ? lvl_q[B_DEC] : lvl_q[B_INC]) &&
                  sw_onehot;
      step_en   = 1'b0;
      step_dec  = act_dec_q;
      step_sel  = sw_lat_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               step_en  = 1'b1;
               step_dec = press[B_DEC];
               step_sel = sw;
            end
         end
         S_HOLD: begin
            if (!abort && (hold_cnt_q == REPEAT_DELAY - 24'd1)) step_en = 1'b1;
         end
         S_REPEAT: begin
            if (!abort && (hold_cnt_q == REPEAT_PERIOD - 24'd1)) step_en = 1'b1;
         end
         default: begin
            step_en = 1'b0;
         end
      endcase
   end

   // Next digit value: only the selected digit may change.
   always_comb begin
      digits_d = digits_q;
      for (int i = 0; i < 4; i++) begin
         if (step_en && step_sel[i])
            digits_d[4*i +: 4] = step_digit(digits_q[4*i +: 4], step_dec);
      end
   end

   // Edit FSM with hold/repeat counter and registered digit value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         hold_cnt_q <= 24'd0;
         act_dec_q  <= 1'b0;
         sw_lat_q   <= 4'd0;
         digits_q   <= 16'd0;
      end else begin
         digits_q <= digits_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_HOLD;
                  hold_cnt_q <= 24'd0;
                  act_dec_q  <= press[B_DEC];
                  sw_lat_q   <= sw;
               end
            end
            S_HOLD: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (hold_cnt_q == REPEAT_DELAY - 24'd1) begin
                  state_q    <= S_REPEAT;
                  hold_cnt_q <= 24'd0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 24'd1;
               end
            end
            S_REPEAT: begin
               if (abort) begin
                  state_q <= S_IDLE;
               end else if (hold_cnt_q == REPEAT_PERIOD - 24'd1) begin
                  hold_cnt_q <= 24'd0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 24'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Commit handshake: capture the value landing this edge, hold until ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         val_data_q  <= 16'd0;
         val_valid_q <= 1'b0;
      end else if (!val_valid_q) begin
         if (press[B_COM]) begin
            val_data_q  <= digits_d;
            val_valid_q <= 1'b1;
         end
      end else if (val_ready) begin
         val_valid_q <= 1'b0;
      end
   end

   assign digits    = digits_q;
   assign val_data  = val_data_q;
   assign val_valid = val_valid_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb_digit_entry_ctrl: directed vectors for digit_entry_ctrl with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4.
// A clean raw press driven just after an edge gives its first step on the
// 7th following edge; a release 1..7 edges later aborts before the HOLD step.
module tb_digit_entry_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  sw;
   logic        btn_inc, btn_dec, btn_commit;
   logic [15:0] digits, val_data;
   logic        val_valid;
   logic        val_ready;

   int n_vec = 0;
   int n_err = 0;

`ifdef DIGIT_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   digit_entry_ctrl #(
      .DEBOUNCE_CYCLES(16'd4),
      .REPEAT_DELAY   (24'd8),
      .REPEAT_PERIOD  (24'd4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw),
      .btn_inc   (btn_inc),
      .btn_dec   (btn_dec),
      .btn_commit(btn_commit),
      .digits    (digits),
      .val_data  (val_data),
      .val_valid (val_valid),
      .val_ready (val_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single clean press-and-release: exactly one step on a one-hot sw.
   task automatic press(input logic [3:0] s, input logic dn);
      sw = s;
      if (dn) btn_dec = 1'b1;
      else    btn_inc = 1'b1;
      tick(7);
      btn_inc = 1'b0;
      btn_dec = 1'b0;
      tick(8);
   endtask

   task automatic commit_press();
      btn_commit = 1'b1;
      tick(7);
      btn_commit = 1'b0;
      tick(8);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      logic [15:0] b2, b3, b4;
      rst = 1'b1; sw = 4'd0; btn_inc = 1'b0; btn_dec = 1'b0;
      btn_commit = 1'b0; val_ready = 1'b0;
      #1;
      tick(2);
      rst = 1'b0;
      check("rst_digits", digits, 16'h0000);
      check("rst_vdata", val_data, 16'h0000);
      check("rst_valid", {15'd0, val_valid}, 16'd0);

      // 1: glitchy press on digit 0, debounced rise at edge 11, step at 12
      sw = 4'b0001; btn_inc = 1'b1;
      tick(3); btn_inc = 1'b0;
      tick(2); btn_inc = 1'b1;
      tick(5);
      check("t1_before_rise", digits, 16'h0000);
      tick(1);
      check("t1_at_rise", digits, 16'h0000);
      tick(1);
      check("t1_step", digits, 16'h0001);
      btn_inc = 1'b0;
      tick(10);
      check("t1_no_extra", digits, 16'h0001);

      // 2: hold inc on digit 2 into auto-repeat
      sw = 4'b0100; btn_inc = 1'b1;
      tick(7);
      check("t2_first", digits, 16'h0101);
      tick(8);
      check("t2_delay", digits, 16'h0201);
      for (int k = 3; k <= 9; k++) begin
         tick(4);
         check($sformatf("t2_rep%0d", k), digits, 16'h0001 | (16'(k) << 8));
      end
      tick(4);
      check("t2_top", digits, WRAP ? 16'h0001 : 16'h0901);
      btn_inc = 1'b0;
      tick(8);
      b2 = WRAP ? 16'h0101 : 16'h0901;
      check("t2_release", digits, b2);

      // 3: decrement at 0 on digit 3, then a multi-hot sw
      press(4'b1000, 1'b1);
      b3 = WRAP ? 16'h9101 : 16'h0901;
      check("t3_dec0", digits, b3);
      press(4'b0011, 1'b0);
      check("t3_multihot", digits, b3);

      // 4: aborts out of REPEAT (dec rises) and out of HOLD (sw changes)
      sw = 4'b0001; btn_inc = 1'b1;
      tick(7);  check("t4_first", digits, b3 + 16'h0001);
      tick(8);  check("t4_delay", digits, b3 + 16'h0002);
      tick(4);  check("t4_rep", digits, b3 + 16'h0003);
      btn_dec = 1'b1;
      tick(4);  check("t4_rep_pre_abort", digits, b3 + 16'h0004);
      tick(7);  check("t4_after_dec_abort", digits, b3 + 16'h0004);
      btn_dec = 1'b0;
      tick(8);  check("t4_dec_low", digits, b3 + 16'h0004);
      btn_inc = 1'b0;
      tick(8);
      press(4'b0001, 1'b0);
      check("t4_repress", digits, b3 + 16'h0005);
      btn_inc = 1'b1;
      tick(7);  check("t4_hold_step", digits, b3 + 16'h0006);
      sw = 4'b0011;
      tick(12); check("t4_after_sw_abort", digits, b3 + 16'h0006);
      sw = 4'b0001;
      tick(8);  check("t4_sw_back", digits, b3 + 16'h0006);
      btn_inc = 1'b0;
      tick(8);
      b4 = b3 + 16'h0006;
      check("t4_end", digits, b4);

      // 5: commit handshake
      rst = 1'b1; tick(1); rst = 1'b0;
      check("t5_rst", digits, 16'h0000);
      press(4'b1000, 1'b0);
      repeat (2) press(4'b0100, 1'b0);
      repeat (3) press(4'b0010, 1'b0);
      repeat (4) press(4'b0001, 1'b0);
      check("t5_digits", digits, 16'h1234);
      btn_commit = 1'b1;
      tick(6);
      check("t5_valid_pre", {15'd0, val_valid}, 16'd0);
      tick(1);
      check("t5_valid", {15'd0, val_valid}, 16'd1);
      check("t5_vdata", val_data, 16'h1234);
      btn_commit = 1'b0;
      tick(8);
      press(4'b0001, 1'b0);
      check("t5_edit", digits, 16'h1235);
      check("t5_vdata_hold", val_data, 16'h1234);
      commit_press();
      check("t5_commit_ignored", val_data, 16'h1234);
      check("t5_still_valid", {15'd0, val_valid}, 16'd1);
      val_ready = 1'b1; tick(1); val_ready = 1'b0;
      check("t5_handshake", {15'd0, val_valid}, 16'd0);
      check("t5_vdata_after", val_data, 16'h1234);

      // 6: reset during REPEAT with a pending handshake
      commit_press();
      check("t6_valid", {15'd0, val_valid}, 16'd1);
      check("t6_vdata", val_data, 16'h1235);
      sw = 4'b0001; btn_inc = 1'b1;
      tick(7);  check("t6_first", digits, 16'h1236);
      tick(8);  check("t6_delay", digits, 16'h1237);
      tick(2);
      rst = 1'b1; tick(1);
      check("t6_rst_digits", digits, 16'h0000);
      check("t6_rst_vdata", val_data, 16'h0000);
      check("t6_rst_valid", {15'd0, val_valid}, 16'd0);
      btn_inc = 1'b0; rst = 1'b0;
      tick(12);
      check("t6_idle", digits, 16'h0000);
      press(4'b0001, 1'b0);
      check("t6_repress", digits, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
